lcd_display_arbiter: RTL and testbench

- Shares the single 16x2 LCD controller between two text sources.
  - The keyboard text path (line buffers built from PS/2 ASCII).
  - A status/message source (e.g. caps/shift banners, error text).
- Captures the winning source's two 128-bit lines and issues an update strobe to the LCD controller.
- Tracks controller busy, holds message frames on screen for a minimum time, then restores keyboard text automatically.
- Sits between the line-buffer blocks and the LCD controller.

---
 rtl/lcd_display_arbiter.sv | 124 ++++++++++++
 tb/tb_lcd_display_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_arbiter.sv
// Arbitrates the 16x2 LCD controller between keyboard text and status messages.
// Message frames are held on screen for a minimum time, then keyboard text is restored.
module lcd_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100_000_000,
  parameter int unsigned HOLD_W      = 27,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic         Clock_100MHz,
  input  logic         Reset,
  input  logic         Kbd_req,
  input  logic [127:0] Kbd_line_1,
  input  logic [127:0] Kbd_line_2,
  output logic         Kbd_gnt,
  input  logic         Msg_req,
  input  logic [127:0] Msg_line_1,
  input  logic [127:0] Msg_line_2,
  output logic         Msg_gnt,
  input  logic         Lcd_busy,
  output logic         Lcd_update,
  output logic [127:0] Line_1,
  output logic [127:0] Line_2,
  output logic         Owner,
  output logic         Lcd_timeout
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ACK_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [LINE_W-1:0] BLANK = {16{8'h20}};

  typedef enum logic [1:0] {IDLE, UPDATE, WAIT_ACK, WAIT_DONE} state_t;

  state_t              state, state_n;
  logic [ACK_W-1:0]    ack_cnt, ack_cnt_n;
  logic [HOLD_W-1:0]   hold, hold_n, hold_load;
  logic [LINE_W-1:0]   line_1_n, line_2_n;
  logic                owner_n, kbd_gnt_n, msg_gnt_n, update_n, timeout_n;

  // State and output registers
  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      state       <= IDLE;
      ack_cnt     <= '0;
      hold        <= '0;
      Line_1      <= BLANK;
      Line_2      <= BLANK;
      Owner       <= 1'b0;
      Kbd_gnt     <= 1'b0;
      Msg_gnt     <= 1'b0;
      Lcd_update  <= 1'b0;
      Lcd_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ack_cnt     <= ack_cnt_n;
      hold        <= hold_n;
      Line_1      <= line_1_n;
      Line_2      <= line_2_n;
      Owner       <= owner_n;
      Kbd_gnt     <= kbd_gnt_n;
      Msg_gnt     <= msg_gnt_n;
      Lcd_update  <= update_n;
      Lcd_timeout <= timeout_n;
    end
  end

  // Only a message frame earns a hold when its write finishes
  assign hold_load = Owner ? HOLD_W'(HOLD_CYCLES) : '0;

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    ack_cnt_n = ack_cnt;
    hold_n    = (hold != '0) ? hold - HOLD_W'(1) : hold;
    line_1_n  = Line_1;
    line_2_n  = Line_2;
    owner_n   = Owner;
    kbd_gnt_n = 1'b0;
    msg_gnt_n = 1'b0;
    update_n  = 1'b0;
    timeout_n = Lcd_timeout;

    case (state)
      IDLE: begin
        if (Msg_req) begin
          line_1_n  = Msg_line_1;
          line_2_n  = Msg_line_2;
          msg_gnt_n = 1'b1;
          owner_n   = 1'b1;
          state_n   = UPDATE;
        end else if (hold == '0 && (Owner || Kbd_req)) begin
          // Restore after a message, or a plain keyboard update
          line_1_n  = Kbd_line_1;
          line_2_n  = Kbd_line_2;
          kbd_gnt_n = Kbd_req;
          owner_n   = 1'b0;
          state_n   = UPDATE;
        end
      end
      UPDATE: begin
        update_n  = 1'b1;
        ack_cnt_n = '0;
        state_n   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (Lcd_busy) begin
          state_n = WAIT_DONE;
        end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
          timeout_n = 1'b1;
          hold_n    = hold_load;
          state_n   = IDLE;
        end else begin
          ack_cnt_n = ack_cnt + ACK_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!Lcd_busy) begin
          hold_n  = hold_load;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Bench for lcd_display_arbiter: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing and values.
module tb_lcd_display_arbiter;

  localparam int HOLD = 20;
  localparam int ACK_TO = 16;

  logic         clk;
  logic         rst;
  logic         kbd_req, msg_req, lcd_busy;
  logic [127:0] kbd_l1, kbd_l2, msg_l1, msg_l2;
  logic         kbd_gnt, msg_gnt, lcd_update, owner, lcd_timeout;
  logic [127:0] line_1, line_2;

  lcd_display_arbiter #(.HOLD_CYCLES(HOLD), .HOLD_W(5), .ACK_TIMEOUT(ACK_TO)) dut (
    .Clock_100MHz(clk),
    .Reset(rst),
    .Kbd_req(kbd_req),
    .Kbd_line_1(kbd_l1),
    .Kbd_line_2(kbd_l2),
    .Kbd_gnt(kbd_gnt),
    .Msg_req(msg_req),
    .Msg_line_1(msg_l1),
    .Msg_line_2(msg_l2),
    .Msg_gnt(msg_gnt),
    .Lcd_busy(lcd_busy),
    .Lcd_update(lcd_update),
    .Line_1(line_1),
    .Line_2(line_2),
    .Owner(owner),
    .Lcd_timeout(lcd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [127:0] blank = {16{8'h20}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // LCD controller model: busy from 2 cycles after the update strobe, for 5 cycles
  int lcd_t = 0;
  bit lcd_en = 1'b1;
  always @(negedge clk) begin
    if (lcd_update === 1'b1 && lcd_en) lcd_t = 1;
    else if (lcd_t > 0) lcd_t = (lcd_t >= 8) ? 0 : lcd_t + 1;
    lcd_busy = (lcd_t >= 3 && lcd_t <= 7);
  end

  // Reference model: a frame is "in flight" from capture until the LCD finishes or
  // times out; the hold is an absolute deadline edge rather than a counter.
  bit           model_valid = 1'b0;
  bit           m_free, m_seen_busy, hold_clear;
  int           m_cap_edge, m_hold_end;
  logic [127:0] e_l1, e_l2;
  bit           e_owner, e_kg, e_mg, e_upd, e_to;

  always @(posedge clk) begin
    cyc++;
    e_kg = 1'b0; e_mg = 1'b0; e_upd = 1'b0;
    if (rst) begin
      model_valid = 1'b1;
      e_l1 = blank; e_l2 = blank; e_owner = 1'b0; e_to = 1'b0;
      m_free = 1'b1; m_seen_busy = 1'b0; m_hold_end = cyc; m_cap_edge = -100;
    end else if (model_valid) begin
      if (m_free) begin
        hold_clear = cyc > m_hold_end;
        if (msg_req) begin
          e_l1 = msg_l1; e_l2 = msg_l2; e_mg = 1'b1; e_owner = 1'b1;
          m_free = 1'b0; m_cap_edge = cyc; m_seen_busy = 1'b0;
        end else if (hold_clear && (e_owner || kbd_req)) begin
          e_l1 = kbd_l1; e_l2 = kbd_l2; e_kg = kbd_req; e_owner = 1'b0;
          m_free = 1'b0; m_cap_edge = cyc; m_seen_busy = 1'b0;
        end
      end else if (cyc == m_cap_edge + 1) begin
        e_upd = 1'b1;
      end else if (m_seen_busy) begin
        if (!lcd_busy) begin
          m_free = 1'b1; m_hold_end = cyc + (e_owner ? HOLD : 0);
        end
      end else if (lcd_busy) begin
        m_seen_busy = 1'b1;
      end else if (cyc - (m_cap_edge + 1) == ACK_TO) begin
        e_to = 1'b1;
        m_free = 1'b1; m_hold_end = cyc + (e_owner ? HOLD : 0);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("kbd_gnt", 128'(kbd_gnt), 128'(e_kg));
      chk("msg_gnt", 128'(msg_gnt), 128'(e_mg));
      chk("lcd_update", 128'(lcd_update), 128'(e_upd));
      chk("owner", 128'(owner), 128'(e_owner));
      chk("lcd_timeout", 128'(lcd_timeout), 128'(e_to));
      chk("line_1", line_1, e_l1);
      chk("line_2", line_2, e_l2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a grant, then drops the request per the requester contract
  task automatic wait_gnt(input bit is_msg, input string nm, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((is_msg ? msg_gnt : kbd_gnt) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (is_msg) msg_req = 1'b0;
    else kbd_req = 1'b0;
    if (at < 0) begin
      compared++; mismatched++;
      $display("FAIL %s: no grant within 100 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int g1, g2, to_at, own_at;
  logic [127:0] hello = "HELLO           ";
  logic [127:0] world = "WORLD           ";

  initial begin
    rst = 1'b1; msg_req = 1'b1; kbd_req = 1'b0;
    kbd_l1 = 128'h0; kbd_l2 = 128'h0;
    msg_l1 = "ERROR           "; msg_l2 = "CODE 42         ";
    tick(3);
    rst = 1'b0; msg_req = 1'b0;
    chk("reset_line_1", line_1, blank);
    chk("reset_owner", 128'(owner), 128'(0));
    tick(3);

    // Keyboard update
    kbd_l1 = hello; kbd_l2 = "LINE TWO        ";
    kbd_req = 1'b1;
    wait_gnt(1'b0, "kbd_first", g1);
    chk("kbd_line_1", line_1, hello);
    tick(1);
    chk("kbd_update_next", 128'(lcd_update), 128'(1));
    tick(15);

    // Message hold, then restore with a pending keyboard request
    msg_l1 = "CAPS LOCK ON    "; msg_l2 = "                ";
    msg_req = 1'b1;
    wait_gnt(1'b1, "msg_hold", g1);
    chk("msg_owner", 128'(owner), 128'(1));
    kbd_l1 = world; kbd_l2 = "AGAIN           ";
    kbd_req = 1'b1;
    wait_gnt(1'b0, "kbd_restore", g2);
    chk("restore_gap", 128'(g2 - g1), 128'(30));
    chk("restore_owner", 128'(owner), 128'(0));
    chk("restore_line_1", line_1, world);
    tick(15);

    // Simultaneous requests: message first, keyboard after hold expiry
    msg_l1 = "SHIFT           "; kbd_l1 = "ABC             ";
    msg_req = 1'b1; kbd_req = 1'b1;
    wait_gnt(1'b1, "simul_msg", g1);
    wait_gnt(1'b0, "simul_kbd", g2);
    chk("simul_gap", 128'(g2 - g1), 128'(30));
    tick(15);

    // LCD never acknowledges
    lcd_en = 1'b0;
    kbd_l1 = "NO ACK          ";
    kbd_req = 1'b1;
    wait_gnt(1'b0, "timeout_kbd", g1);
    to_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lcd_timeout === 1'b1) begin
        to_at = cyc;
        break;
      end
    end
    chk("timeout_delay", 128'(to_at - g1), 128'(17));
    lcd_en = 1'b1;
    tick(2);
    kbd_l1 = "AFTER TIMEOUT   ";
    kbd_req = 1'b1;
    wait_gnt(1'b0, "post_timeout_kbd", g1);
    tick(15);
    chk("timeout_sticky", 128'(lcd_timeout), 128'(1));

    // Preemption at hold=10, then restore without a keyboard request
    msg_l1 = "MSG ONE         ";
    msg_req = 1'b1;
    wait_gnt(1'b1, "preempt_first", g1);
    while (cyc < g1 + 19) @(negedge clk);
    msg_l1 = "MSG TWO         ";
    msg_req = 1'b1;
    wait_gnt(1'b1, "preempt_second", g2);
    chk("preempt_latency", 128'(g2 - g1), 128'(20));
    own_at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (owner === 1'b0) begin
        own_at = cyc;
        break;
      end
    end
    chk("preempt_reload", 128'(own_at - g2), 128'(30));
    tick(15);

    // Reset while the LCD is busy with a message frame
    msg_l1 = "RESET ME        ";
    msg_req = 1'b1;
    wait_gnt(1'b1, "midreset_msg", g1);
    for (int i = 0; i < 20 && lcd_busy !== 1'b1; i++) @(negedge clk);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midreset_line_1", line_1, blank);
    chk("midreset_owner", 128'(owner), 128'(0));
    chk("midreset_timeout", 128'(lcd_timeout), 128'(0));
    tick(10);
    kbd_l1 = "BACK            ";
    kbd_req = 1'b1;
    wait_gnt(1'b0, "post_reset_kbd", g1);
    tick(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
